fpu_wb_ctrl: RTL

- Wishbone slave register front-end that sits directly upstream of the FPU core in the user project.
- Captures operands, opcode and rounding mode from the management SoC, then issues a one-cycle start to the FPU.
- Waits for the core's done pulse, latches result and exception flags, and raises a maskable interrupt.
- A watchdog counter aborts operations that never complete.

---
 rtl/fpu_wb_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fpu_wb_ctrl.sv
// Wishbone register front-end for the FPU core: operand/opcode capture, launch,
// result/flag capture, watchdog abort and maskable interrupt.
module fpu_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        irq
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RESULT = 8'h10;
  localparam logic [7:0] OFF_IRQEN  = 8'h14;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          done;
  logic          tout;
  logic          ovr;
  logic [4:0]    flags;
  logic [31:0]   result;
  logic [1:0]    irqen;

  logic        hit;
  logic        acc;
  logic        wr;
  logic        busy;
  logic        op_reg_wr;
  logic [7:0]  off;
  logic [31:0] rdata;

  // An access is taken only when ack is low, which forces a gap between acks.
  assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc       = hit & ~wbs_ack_o;
  assign wr        = acc & wbs_we_i;
  assign off       = wbs_adr_i[7:0];
  assign busy      = (state != IDLE);
  assign op_reg_wr = wr & ((off == OFF_OPA) | (off == OFF_OPB) | (off == OFF_CTRL));

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OPA:    rdata = fpu_opa;
      OFF_OPB:    rdata = fpu_opb;
      OFF_CTRL:   rdata = {27'd0, fpu_rmode, fpu_op};
      OFF_STATUS: rdata = {23'd0, flags, ovr, tout, done, busy};
      OFF_RESULT: rdata = result;
      OFF_IRQEN:  rdata = {30'd0, irqen};
      default:    rdata = '0;
    endcase
  end

  // Later assignments in this block take priority, so hardware sets beat W1C.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      tout      <= 1'b0;
      ovr       <= 1'b0;
      flags     <= '0;
      result    <= '0;
      irqen     <= '0;
      fpu_opa   <= '0;
      fpu_opb   <= '0;
      fpu_op    <= '0;
      fpu_rmode <= '0;
      fpu_start <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq       <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : '0;
      irq       <= (done & irqen[0]) | (tout & irqen[1]);
      fpu_start <= 1'b0;

      if (wr && off == OFF_STATUS) begin
        if (wbs_dat_i[1]) done <= 1'b0;
        if (wbs_dat_i[2]) tout <= 1'b0;
        if (wbs_dat_i[3]) ovr  <= 1'b0;
      end
      if (wr && off == OFF_IRQEN) irqen <= wbs_dat_i[1:0];

      if (op_reg_wr && busy) begin
        ovr <= 1'b1;
      end else if (op_reg_wr) begin
        case (off)
          OFF_OPA: begin
            for (int i = 0; i < 4; i++)
              if (wbs_sel_i[i]) fpu_opa[8*i +: 8] <= wbs_dat_i[8*i +: 8];
          end
          OFF_OPB: begin
            for (int i = 0; i < 4; i++)
              if (wbs_sel_i[i]) fpu_opb[8*i +: 8] <= wbs_dat_i[8*i +: 8];
          end
          default: begin
            fpu_op    <= wbs_dat_i[2:0];
            fpu_rmode <= wbs_dat_i[4:3];
            if (wbs_dat_i[8]) begin
              state     <= START;
              fpu_start <= 1'b1;
              done      <= 1'b0;
              tout      <= 1'b0;
            end
          end
        endcase
      end

      case (state)
        START: begin
          cnt   <= CW'(TIMEOUT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (fpu_done) begin
            result <= fpu_result;
            flags  <= fpu_flags;
            done   <= 1'b1;
            state  <= IDLE;
          end else if (cnt == '0) begin
            tout  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
